// File: rtl/adder_rr_ctrl_if.sv
// Bus between the round-robin controller and the shared adder datapath.
// The controller owns the operands and enable; the adder returns sum and carry-out.
interface adder_rr_ctrl_if #(
  parameter int W = 8
);
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_en;
  logic [W-1:0] add_t;
  logic         add_flag;

  modport master (
    output add_a,
    output add_b,
    output add_en,
    input  add_t,
    input  add_flag
  );

  modport slave (
    input  add_a,
    input  add_b,
    input  add_en,
    output add_t,
    output add_flag
  );
endinterface

// File: rtl/adder_rr_ctrl.sv
// Two-requester round-robin scheduler for one shared adder: grant, issue for one
// cycle, capture sum/carry into per-requester registers, then pulse done.
module adder_rr_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  input  logic             req1,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  output logic             done0,
  output logic [W-1:0]     res0,
  output logic             flag0,
  output logic             done1,
  output logic [W-1:0]     res1,
  output logic             flag1,
  adder_rr_ctrl_if.master  add,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         grant;
  logic         grant_id;
  logic         gid;
  logic         last;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // On contention the requester that did not win last time is granted.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = 1'b0;
    busy      = 1'b0;
    add.add_en = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          grant_id  = (req0 && req1) ? ~last : req1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy       = 1'b1;
        add.add_en = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done0     = ~gid;
        done1     = gid;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operands are frozen at the grant edge so the adder sees stable inputs in ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gid  <= 1'b0;
      last <= 1'b1;
      op_a <= '0;
      op_b <= '0;
    end else if (grant) begin
      gid  <= grant_id;
      last <= grant_id;
      op_a <= grant_id ? a1 : a0;
      op_b <= grant_id ? b1 : b0;
    end
  end

  assign add.add_a = op_a;
  assign add.add_b = op_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res0   <= '0;
      flag0  <= 1'b0;
      res1   <= '0;
      flag1  <= 1'b0;
      op_cnt <= '0;
    end else if (state == ISSUE) begin
      if (gid) begin
        res1  <= add.add_t;
        flag1 <= add.add_flag;
      end else begin
        res0  <= add.add_t;
        flag0 <= add.add_flag;
      end
      op_cnt <= op_cnt + CNT_W'(1);
    end
  end

endmodule
